parking_gate_ctrl: RTL and testbench



---
 rtl/parking_gate_ctrl.sv | 169 ++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Single-gate parking entry controller: password check, retry limit with timed lockout,
// occupancy tracking and barrier control. Optional macro PARK_PW_PROG_EN adds a writable password.
module parking_gate_ctrl #(
  parameter int                  PW_WIDTH    = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD    = 4'b1011,
  parameter int                  CAPACITY    = 8,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  GATE_CYCLES = 16,
  parameter int                  LOCK_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          front_sensor,
  input  logic                          back_sensor,
  input  logic                          exit_sensor,
  input  logic                          pw_valid,
  input  logic [PW_WIDTH-1:0]           pw_in,
`ifdef PARK_PW_PROG_EN
  input  logic                          pw_prog_we,
  input  logic [PW_WIDTH-1:0]           pw_prog_data,
`endif
  output logic                          gate_open,
  output logic                          green_led,
  output logic                          red_led,
  output logic                          wrong_pw,
  output logic                          locked,
  output logic                          full,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy
);

  localparam int OCC_W   = $clog2(CAPACITY + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PW,
    GRANT,
    PASSING,
    LOCKOUT
  } state_t;

  state_t             state, next_state;
  logic [TRY_W-1:0]   tries, tries_next;
  logic [TMR_W-1:0]   timer, timer_next;
  logic [OCC_W-1:0]   occ_next;
  logic [PW_WIDTH-1:0] active_pw;
  logic               car_in, car_out;
  logic               gate_d, green_d, red_d, wrong_d, locked_d;

`ifdef PARK_PW_PROG_EN
  logic [PW_WIDTH-1:0] pw_reg;

  // Programming only while idle, so a password in flight is never compared against a moving target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            pw_reg <= PASSWORD;
    else if (pw_prog_we && state == IDLE) pw_reg <= pw_prog_data;
  end

  assign active_pw = pw_reg;
`else
  assign active_pw = PASSWORD;
`endif

  assign full = (occupancy == OCC_W'(CAPACITY));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    tries_next = tries;
    timer_next = '0;
    wrong_d    = 1'b0;
    red_d      = 1'b0;
    car_in     = 1'b0;

    unique case (state)
      IDLE: begin
        if (front_sensor) begin
          if (!full) next_state = WAIT_PW;
          else       red_d      = 1'b1;
        end
      end

      WAIT_PW: begin
        if (pw_valid) begin
          if (pw_in == active_pw) begin
            next_state = GRANT;
            tries_next = '0;
          end else begin
            wrong_d    = 1'b1;
            red_d      = 1'b1;
            tries_next = tries + 1'b1;
            if (tries == TRY_W'(MAX_TRIES - 1)) next_state = LOCKOUT;
          end
        end else if (!front_sensor) begin
          next_state = IDLE;
        end
      end

      GRANT: begin
        if (back_sensor)                             next_state = PASSING;
        else if (timer == TMR_W'(GATE_CYCLES - 1))   next_state = IDLE;
        else                                         timer_next = timer + 1'b1;
      end

      PASSING: begin
        // Entry required back_sensor high, so a low sample here is the falling edge.
        if (!back_sensor) begin
          next_state = IDLE;
          car_in     = 1'b1;
        end else begin
          timer_next = timer;
        end
      end

      LOCKOUT: begin
        if (timer == TMR_W'(LOCK_CYCLES - 1)) begin
          next_state = IDLE;
          tries_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      default: next_state = IDLE;
    endcase

    gate_d   = (next_state == GRANT) || (next_state == PASSING);
    green_d  = (next_state == GRANT);
    locked_d = (next_state == LOCKOUT);
    red_d    = red_d || locked_d;
  end

  // A departure at zero is dropped before it can cancel a simultaneous arrival.
  assign car_out = exit_sensor && (occupancy != '0);

  always_comb begin
    occ_next = occupancy;
    if (car_in && !car_out)      occ_next = occupancy + 1'b1;
    else if (!car_in && car_out) occ_next = occupancy - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tries     <= '0;
      timer     <= '0;
      occupancy <= '0;
      gate_open <= 1'b0;
      green_led <= 1'b0;
      red_led   <= 1'b0;
      wrong_pw  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= next_state;
      tries     <= tries_next;
      timer     <= timer_next;
      occupancy <= occ_next;
      gate_open <= gate_d;
      green_led <= green_d;
      red_led   <= red_d;
      wrong_pw  <= wrong_d;
      locked    <= locked_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios plus random traffic,
// compared each cycle against a deadline-based behavioural model of the gate.
module tb_parking_gate_ctrl;

  localparam int         PW_WIDTH    = 4;
  localparam logic [3:0] PASSWORD    = 4'b1011;
  localparam int         CAPACITY    = 8;
  localparam int         MAX_TRIES   = 3;
  localparam int         GATE_CYCLES = 16;
  localparam int         LOCK_CYCLES = 64;
  localparam int         OCC_W       = $clog2(CAPACITY + 1);

  logic             clk;
  logic             reset;
  logic             front_sensor, back_sensor, exit_sensor, pw_valid;
  logic [3:0]       pw_in;
  logic             gate_open, green_led, red_led, wrong_pw, locked, full;
  logic [OCC_W-1:0] occupancy;

  parking_gate_ctrl #(
    .PW_WIDTH   (PW_WIDTH),
    .PASSWORD   (PASSWORD),
    .CAPACITY   (CAPACITY),
    .MAX_TRIES  (MAX_TRIES),
    .GATE_CYCLES(GATE_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .front_sensor(front_sensor),
    .back_sensor (back_sensor),
    .exit_sensor (exit_sensor),
    .pw_valid    (pw_valid),
    .pw_in       (pw_in),
`ifdef PARK_PW_PROG_EN
    .pw_prog_we  (1'b0),
    .pw_prog_data(4'b0000),
`endif
    .gate_open   (gate_open),
    .green_led   (green_led),
    .red_led     (red_led),
    .wrong_pw    (wrong_pw),
    .locked      (locked),
    .full        (full),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: where the car/driver is, plus absolute-cycle deadlines instead of counters.
  typedef enum {M_IDLE, M_PW, M_OPEN, M_PASS, M_LOCK} mode_t;
  mode_t m_mode;
  int    m_cars, m_misses, m_edge, m_open_deadline, m_lock_end;
  bit    e_wrong, e_red;

  int total, bad;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_IDLE; m_cars = 0; m_misses = 0; m_edge = 0;
    m_open_deadline = 0; m_lock_end = 0; e_wrong = 0; e_red = 0;
  endfunction

  function automatic void model_edge(bit f, bit b, bit x, bit pv, logic [3:0] pw);
    bit arrived = 0;
    bit was_full = (m_cars == CAPACITY);
    m_edge++;
    e_wrong = 0;
    e_red   = 0;
    case (m_mode)
      M_IDLE: if (f) begin
        if (!was_full) m_mode = M_PW;
        else           e_red  = 1;
      end
      M_PW: if (pv) begin
        if (pw == PASSWORD) begin
          m_mode = M_OPEN; m_misses = 0; m_open_deadline = m_edge + GATE_CYCLES;
        end else begin
          e_wrong = 1; e_red = 1; m_misses++;
          if (m_misses == MAX_TRIES) begin
            m_mode = M_LOCK; m_lock_end = m_edge + LOCK_CYCLES;
          end
        end
      end else if (!f) m_mode = M_IDLE;
      M_OPEN: if (b) m_mode = M_PASS;
              else if (m_edge == m_open_deadline) m_mode = M_IDLE;
      M_PASS: if (!b) begin m_mode = M_IDLE; arrived = 1; end
      M_LOCK: if (m_edge == m_lock_end) begin m_mode = M_IDLE; m_misses = 0; end
      default: m_mode = M_IDLE;
    endcase
    if (x && m_cars > 0) m_cars--;
    if (arrived)         m_cars++;
    if (m_mode == M_LOCK) e_red = 1;
  endfunction

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step(input bit f, input bit b, input bit x, input bit pv, input logic [3:0] pw);
    front_sensor = f; back_sensor = b; exit_sensor = x; pw_valid = pv; pw_in = pw;
    model_edge(f, b, x, pv, pw);
    @(negedge clk);
    check("gate_open", gate_open, (m_mode == M_OPEN || m_mode == M_PASS) ? 1 : 0);
    check("green_led", green_led, (m_mode == M_OPEN) ? 1 : 0);
    check("red_led",   red_led,   e_red ? 1 : 0);
    check("wrong_pw",  wrong_pw,  e_wrong ? 1 : 0);
    check("locked",    locked,    (m_mode == M_LOCK) ? 1 : 0);
    check("full",      full,      (m_cars == CAPACITY) ? 1 : 0);
    check("occupancy", occupancy, m_cars);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 4'b0000);
  endtask

  task automatic enter_car();
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 1, PASSWORD);
    repeat (3) step(0, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 4'b0000);
  endtask

  int cnt;

  initial begin
    total = 0; bad = 0;
    front_sensor = 0; back_sensor = 0; exit_sensor = 0; pw_valid = 0; pw_in = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_gate", gate_open, 0);
    check("reset_occ",  occupancy, 0);
    check("reset_red",  red_led,   0);
    check("reset_lock", locked,    0);
    reset = 1'b0;
    idle_step();

    // Basic entry: gate opens one cycle after the correct password, count after back falls.
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 1, PASSWORD);
    check("t1_gate_open", gate_open, 1);
    repeat (3) step(0, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 4'b0000);
    check("t1_gate_closed", gate_open, 0);
    check("t1_occ", occupancy, 1);

    // Gate timeout without a car passing.
    step(1, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 1, PASSWORD);
    cnt = gate_open;
    repeat (20) begin
      idle_step();
      cnt += gate_open;
    end
    check("t4_open_cycles", cnt, GATE_CYCLES);
    check("t4_occ", occupancy, 1);

    // Three wrong passwords, lockout, correct password ignored while locked.
    step(1, 0, 0, 0, 4'b0000);
    repeat (MAX_TRIES) step(1, 0, 0, 1, 4'b0000);
    cnt = locked;
    for (int i = 0; i < 70; i++) begin
      if (i == 10) begin
        step(1, 0, 0, 1, PASSWORD);
        check("t2_pw_ignored", gate_open, 0);
      end else begin
        step(1, 0, 0, 0, 4'b0000);
      end
      cnt += locked;
    end
    check("t2_lock_cycles", cnt, LOCK_CYCLES);
    step(1, 0, 0, 1, PASSWORD);
    check("t2_open_after_lock", gate_open, 1);
    step(0, 1, 0, 0, 4'b0000);
    idle_step();
    check("t2_occ", occupancy, 2);

    // Fill the lot, refuse entry, free a slot, enter again.
    repeat (CAPACITY - 2) enter_car();
    check("t3_full", full, 1);
    repeat (3) step(1, 0, 0, 0, 4'b0000);
    check("t3_red", red_led, 1);
    check("t3_gate_closed", gate_open, 0);
    step(0, 0, 1, 0, 4'b0000);
    check("t3_occ_after_exit", occupancy, CAPACITY - 1);
    enter_car();
    check("t3_occ_refilled", occupancy, CAPACITY);

    // Arrival coincident with a departure, then underflow guard.
    repeat (CAPACITY - 4) step(0, 0, 1, 0, 4'b0000);
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 1, PASSWORD);
    repeat (2) step(0, 1, 0, 0, 4'b0000);
    step(0, 0, 1, 0, 4'b0000);
    check("t5_occ_simul", occupancy, 4);
    repeat (5) step(0, 0, 1, 0, 4'b0000);
    check("t5_occ_floor", occupancy, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         f  = ($urandom_range(0, 3) != 0);
      bit         b  = ($urandom_range(0, 2) == 0);
      bit         x  = ($urandom_range(0, 7) == 0);
      bit         pv = ($urandom_range(0, 3) == 0);
      logic [3:0] pw = ($urandom_range(0, 2) != 0) ? PASSWORD : 4'($urandom);
      step(f, b, x, pv, pw);
    end

    // Asynchronous reset while a car is passing.
    repeat (LOCK_CYCLES + GATE_CYCLES + 4) idle_step();
    step(0, 0, 1, 0, 4'b0000);
    enter_car();
    step(1, 0, 0, 0, 4'b0000);
    step(0, 0, 0, 1, PASSWORD);
    step(0, 1, 0, 0, 4'b0000);
    check("t6_pre_gate", gate_open, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_gate_async", gate_open, 0);
    check("t6_occ_async",  occupancy, 0);
    check("t6_lock_async", locked,    0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
